// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register of the 16-bit MIPS pipeline.
// Owns the PC, applies stall/redirect, and sequences HALT detect -> drain -> halted.
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [15:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [3:0]  id_funct,
  output logic        halted
);

  localparam int unsigned CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [15:0]    pc_r, pc_s;
  logic           id_valid_r, id_valid_s;
  logic [31:0]    id_instr_r, id_instr_s;
  logic [15:0]    id_pc_plus4_r, id_pc_plus4_s;
  logic [CW-1:0]  count_r, count_s;
  logic           halted_r, halted_s;
  logic [15:0]    target_s;
  logic [15:0]    pc_inc_s;

  assign target_s = redirect_pc & 16'hFFFC;
  assign pc_inc_s = pc_r + 16'd4;

  // Next-state and IF/ID update; redirect beats stall beats advance outside HALTED
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    id_valid_s    = id_valid_r;
    id_instr_s    = id_instr_r;
    id_pc_plus4_s = id_pc_plus4_r;
    count_s       = count_r;
    halted_s      = halted_r;
    case (state_r)
      RUN: begin
        if (redirect_valid) begin
          pc_s          = target_s;
          id_valid_s    = 1'b0;
          id_instr_s    = 32'h0000_0000;
          id_pc_plus4_s = 16'h0000;
        end else if (stall) begin
          state_s = RUN;
        end else begin
          id_valid_s    = 1'b1;
          id_instr_s    = imem_rdata;
          id_pc_plus4_s = pc_inc_s;
          if (imem_rdata[31:26] == HALT_OPCODE) begin
            state_s = HALT_PEND;
          end else begin
            pc_s = pc_inc_s;
          end
        end
      end
      HALT_PEND: begin
        if (redirect_valid) begin
          pc_s          = target_s;
          id_valid_s    = 1'b0;
          id_instr_s    = 32'h0000_0000;
          id_pc_plus4_s = 16'h0000;
          state_s       = RUN;
        end else if (stall) begin
          state_s = HALT_PEND;
        end else begin
          id_valid_s    = 1'b0;
          id_instr_s    = 32'h0000_0000;
          id_pc_plus4_s = 16'h0000;
          count_s       = DRAIN_LOAD;
          state_s       = DRAIN;
        end
      end
      DRAIN: begin
        // A redirect here comes from an older branch, so the HALT never retires
        if (redirect_valid) begin
          pc_s          = target_s;
          id_valid_s    = 1'b0;
          id_instr_s    = 32'h0000_0000;
          id_pc_plus4_s = 16'h0000;
          count_s       = '0;
          state_s       = RUN;
        end else if (stall) begin
          count_s = count_r;
        end else if (count_r == CNT_ONE) begin
          count_s  = '0;
          halted_s = 1'b1;
          state_s  = HALTED;
        end else begin
          count_s = count_r - CNT_ONE;
        end
      end
      HALTED: begin
        halted_s = 1'b1;
      end
      default: begin
        state_s       = RUN;
        pc_s          = RESET_PC;
        id_valid_s    = 1'b0;
        id_instr_s    = 32'h0000_0000;
        id_pc_plus4_s = 16'h0000;
        count_s       = '0;
        halted_s      = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      pc_r          <= RESET_PC;
      id_valid_r    <= 1'b0;
      id_instr_r    <= 32'h0000_0000;
      id_pc_plus4_r <= 16'h0000;
      count_r       <= '0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      id_valid_r    <= id_valid_s;
      id_instr_r    <= id_instr_s;
      id_pc_plus4_r <= id_pc_plus4_s;
      count_r       <= count_s;
      halted_r      <= halted_s;
    end
  end

  assign imem_addr   = pc_r;
  assign id_valid    = id_valid_r;
  assign id_instr    = id_instr_r;
  assign id_pc_plus4 = id_pc_plus4_r;
  assign id_opcode   = id_instr_r[31:26];
  assign id_funct    = id_instr_r[3:0];
  assign halted      = halted_r;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit MIPS pipeline.
- Sits directly upstream of the decode control logic and supplies it with opcode, funct, instruction and PC+4.
- Owns the PC, honours stall and redirect requests from downstream hazard/branch logic, and runs the HALT shutdown sequence: halt detect, pipeline drain, then the halted flag.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bits [1:0] must be 0.
- DRAIN_CYCLES, 3, cycles after HALT leaves ID before halted asserts (covers EX/MEM/WB).
- HALT_OPCODE, 6'b111111, opcode recognised as HALT.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  16  instruction memory byte address; equals the PC register.
- imem_rdata  input  32  instruction word; combinational read of imem_addr, valid in the same cycle.
- stall  input  1  hold PC and IF/ID (load-use hazard).
- redirect_valid  input  1  taken branch/jump/JR resolved downstream; flush and redirect.
- redirect_pc  input  16  target address; bits [1:0] ignored and forced to 0.
- id_valid  output  1  IF/ID holds a real instruction.
- id_instr  output  32  IF/ID instruction; 32'h0 when bubble.
- id_pc_plus4  output  16  PC+4 of the instruction in IF/ID (JAL link / branch base).
- id_opcode  output  6  id_instr[31:26], combinational from the register.
- id_funct  output  4  id_instr[3:0], combinational from the register.
- halted  output  1  processor has halted; registered.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, id_valid=0, id_instr=0, id_pc_plus4=0.
  - state=RUN, drain count=0, halted=0.
- Bubble: id_instr=32'h0 and id_valid=0. All-zero decodes as an R-type write to $0, so it is architecturally a no-op. Consumers also gate on id_valid.
- PC arithmetic is 16-bit modulo: 16'hFFFC+4=16'h0000.
- Priority in every non-HALTED state: redirect_valid > stall > normal advance.
- States: RUN, HALT_PEND, DRAIN, HALTED.
- RUN:
  - Redirect: pc<=redirect_pc&~3; IF/ID<=bubble.
  - Else if stall: pc and IF/ID hold.
  - Else (advance): id_instr<=imem_rdata; id_valid<=1; id_pc_plus4<=pc+4.
    - If imem_rdata[31:26]==HALT_OPCODE: pc holds; state<=HALT_PEND.
    - Otherwise pc<=pc+4.
- HALT_PEND (HALT sits in IF/ID, no further fetch):
  - Redirect: flush IF/ID; pc<=redirect target; state<=RUN. The HALT was on a wrong path.
  - Else if stall: hold everything.
  - Else: IF/ID<=bubble; count<=DRAIN_CYCLES; state<=DRAIN.
- DRAIN:
  - Redirect: state<=RUN, pc<=target, IF/ID bubble. An older branch cancelled the HALT.
  - Else if stall: count holds.
  - Else if count==1: state<=HALTED, halted<=1.
  - Otherwise count<=count-1.
  - DRAIN_CYCLES=0 is illegal. With DRAIN_CYCLES=N, halted rises exactly N unstalled cycles after entering DRAIN.
- HALTED:
  - Terminal until reset; redirect and stall are ignored.
  - pc, IF/ID bubble and halted=1 all hold.
- Latency:
  - An instruction at address A appears on id_* one cycle after imem_addr==A, given no stall or redirect in that cycle.
  - A redirect takes effect on the next edge: the target is fetched in the following cycle and appears in IF/ID one cycle later. Exactly one bubble is inserted.
- Simultaneous stall+redirect: the redirect wins and the stall is dropped.
- Reset mid-halt or mid-drain returns immediately to RUN at RESET_PC with halted=0.

Test Plan:
- Sequential fetch: reset, imem returns words W0,W1,W2 at 0x0,0x4,0x8 -> id_instr=W0,W1,W2 on cycles 1-3; id_pc_plus4=0x4,0x8,0xC; id_opcode/id_funct match bits [31:26]/[3:0].
- Stall: assert stall for 2 cycles while id_instr=W1 -> id_instr stays W1 and imem_addr stays 0x8; fetch resumes with W2 afterwards.
- Redirect: redirect_valid=1, redirect_pc=0x0043 with stall=1 in the same cycle -> next cycle id_valid=0, id_instr=0, imem_addr=0x0040; the target instruction appears in IF/ID the cycle after.
- Wrap-around: start at RESET_PC=0xFFFC -> imem_addr goes 0xFFFC then 0x0000; id_pc_plus4=0x0000.
- Halt: fetch 32'hFC000000 -> HALT_PEND with pc frozen; bubble next cycle; with DRAIN_CYCLES=3, halted=1 exactly 3 cycles later and stays 1 under later redirect/stall. A 1-cycle stall during DRAIN delays halted by 1.
- Halt cancel: redirect during HALT_PEND or DRAIN -> halted stays 0, fetch restarts at the target; async rst_n low while HALTED -> halted=0, pc=RESET_PC immediately.
